count_step_monitor: RTL
=======================

// Module: count_step_monitor
// PURPOSE
//  Consumes the 4-bit count stream of the skip up/down counter stage, one sample per cycle.
//  Checks every step against the legal pattern:
//   - up phase: +1/+2, turning at TOP.
//   - down phase: -1/-2, turning at BOTTOM.
//  Reports direction, turnaround pulses, lap count and step errors to downstream status logic.
// PARAMETERS
//  WIDTH   4   width of in_count / prev_count
//  TOP     14  turnaround value: up phase ends here
//  BOTTOM  1   turnaround value: down phase ends here
//  LAP_W   8   width of lap_count
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous reset, ACTIVE-LOW (rst==0 resets)
//  in_valid    in   1       in_count valid this cycle; low = hold
//  in_count    in   WIDTH   count sample from upstream counter
//  clr         in   1       sync clear of err_sticky and lap_count
//  dir         out  1       current phase: 0 = up, 1 = down
//  peak        out  1       1-cycle pulse: legal arrival at TOP
//  valley      out  1       1-cycle pulse: legal arrival at BOTTOM
//  step_err    out  1       1-cycle pulse: illegal step detected
//  err_code    out  2       cause of last step_err; holds until next error
//  err_sticky  out  1       set on any step_err, cleared by clr
//  lap_count   out  LAP_W   completed down phases (valleys), saturating
//  prev_count  out  WIDTH   last accepted sample
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - state=INIT; all outputs 0.
//   - Overrides clr and in_valid.
//  Timing:
//   - All outputs registered: response appears 1 cycle after the accepted sample.
//   - in_valid==0: state/prev/lap/err hold; peak/valley/step_err drop to 0.
//  FSM states: INIT, UP, DOWN.
//  INIT, first valid sample:
//   - prev_count<=in_count; no checks, no pulses.
//   - ->DOWN if in_count==TOP, else ->UP.
//  Step arithmetic:
//   - d = in_count - prev_count, modulo 2^WIDTH.
//   - Legal up step: d==1 or d==2. Legal down step: d==2^WIDTH-1 or d==2^WIDTH-2.
//  UP, legal step and in_count<=TOP:
//   - in_count==TOP -> peak=1, ->DOWN (dir=1). Else stay UP.
//  DOWN, legal step and in_count>=BOTTOM:
//   - in_count==BOTTOM -> valley=1, lap_count+1 (saturate at all-ones), ->UP (dir=0).
//   - Else stay DOWN.
//  Error codes (first match wins):
//   - 01 stall: d==0.
//   - 10 wrong direction: legal step of the opposite phase.
//   - 11 magnitude: any other d, or value beyond TOP (up) / below BOTTOM (down).
//  On error:
//   - step_err=1, err_code updated, err_sticky=1.
//   - No peak/valley, lap_count unchanged.
//   - Resync: in_count==TOP ->DOWN; in_count==BOTTOM ->UP; else phase unchanged.
//  prev_count<=in_count on every valid sample, including error samples.
//  clr:
//   - Zeroes err_sticky and lap_count; err_code holds.
//   - Same-cycle error: err_sticky ends 1.
//   - Same-cycle valley: lap_count ends 0.
//  Reset mid-stream: returns to INIT; next valid sample is baseline only.
// CONFIGURATION
//  STEP_MON_ERRCNT_EN defined:
//   - Adds output err_count [7:0].
//   - Counts step_err pulses, saturating at 255; cleared by reset and clr.
//  STEP_MON_ERRCNT_EN undefined:
//   - Port and counter absent; error visibility via err_sticky/err_code only.
// TESTING
//  T1 reset:
//   - rst=0 for 2 cycles, valid stream running -> all outputs 0.
//   - First sample after release 0 -> no pulse, dir=0.
//  T2 full legal lap:
//   - Feed 0,1,2,4,5,6,8..14 then 13,12,10..1 -> single peak on 14, dir=1.
//   - Valley on 1, lap_count=1, step_err never set.
//  T3 errors:
//   - In UP, 5,5 -> step_err, err_code=01.
//   - 5,4 in UP -> err_code=10, phase stays UP.
//   - 5,9 -> err_code=11.
//   - err_sticky=1 throughout.
//  T4 overshoot/resync:
//   - UP 13->15 -> err_code=11, no peak.
//   - Sample 14 with d=15 in UP -> error 10, no peak; resync to DOWN (dir=1).
//  T5 hold and clr:
//   - in_valid=0 for 5 cycles mid-lap -> outputs frozen, pulses 0.
//   - clr with simultaneous valley -> lap_count=0.
//  T6 saturation:
//   - LAP_W=2, 5 laps -> lap_count=3.
//   - ERRCNT_EN build, 300 errors -> err_count=255.

Source files
------------

// File: rtl/count_step_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_step_monitor
// Description : Watches the 4-bit count stream of the skip up/down counter
//               stage, one sample per cycle. Each accepted sample is checked
//               against the legal pattern (+1/+2 going up and turning at TOP,
//               -1/-2 going down and turning at BOTTOM). The monitor reports
//               the phase, turnaround pulses, completed laps and step errors.
//
// Ports       : clk        rising-edge clock
//               rst        synchronous reset, active low (rst==0 resets)
//               in_valid   in_count is valid this cycle; low = hold
//               in_count   count sample from the upstream counter
//               clr        synchronous clear of err_sticky and lap_count
//               dir        current phase: 0 = up, 1 = down
//               peak       1-cycle pulse on a legal arrival at TOP
//               valley     1-cycle pulse on a legal arrival at BOTTOM
//               step_err   1-cycle pulse on an illegal step
//               err_code   cause of the last error (01 stall, 10 wrong
//                          direction, 11 magnitude); holds until next error
//               err_sticky set on any error, cleared by clr
//               lap_count  completed down phases (valleys), saturating
//               prev_count last accepted sample
//               err_count  (only with STEP_MON_ERRCNT_EN) saturating count
//                          of step_err pulses, cleared by reset and clr
//
// Build option: define STEP_MON_ERRCNT_EN to add the err_count output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module count_step_monitor #(
    parameter int WIDTH  = 4,
    parameter int TOP    = 14,
    parameter int BOTTOM = 1,
    parameter int LAP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    input  logic             clr,
    output logic             dir,
    output logic             peak,
    output logic             valley,
    output logic             step_err,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [LAP_W-1:0] lap_count,
    output logic [WIDTH-1:0] prev_count
`ifdef STEP_MON_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    // Step values, all taken modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] c_plus1  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_plus2  = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_minus1 = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_minus2 = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] c_top    = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] c_bottom = WIDTH'(BOTTOM);

    localparam logic [1:0] c_err_stall = 2'b01;
    localparam logic [1:0] c_err_dir   = 2'b10;
    localparam logic [1:0] c_err_mag   = 2'b11;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_dir;
    logic               r_peak;
    logic               r_valley;
    logic               r_step_err;
    logic [1:0]         r_err_code;
    logic               r_err_sticky;
    logic [LAP_W-1:0]   r_lap_count;
    logic [WIDTH-1:0]   r_prev_count;

    logic [WIDTH-1:0]   w_delta;
    logic               w_up_step;
    logic               w_dn_step;
    logic               w_at_top;
    logic               w_at_bottom;
    state_t             w_next;
    logic               w_peak;
    logic               w_valley;
    logic               w_err;
    logic [1:0]         w_code;

    assign w_delta     = in_count - r_prev_count;
    assign w_up_step   = (w_delta == c_plus1)  || (w_delta == c_plus2);
    assign w_dn_step   = (w_delta == c_minus1) || (w_delta == c_minus2);
    assign w_at_top    = (in_count == c_top);
    assign w_at_bottom = (in_count == c_bottom);

    // Classify the current sample; only meaningful when in_valid is high.
    always_comb begin
        w_next   = r_state;
        w_peak   = 1'b0;
        w_valley = 1'b0;
        w_err    = 1'b0;
        w_code   = 2'b00;

        case (r_state)
            S_INIT: begin
                // First sample is a baseline only.
                w_next = w_at_top ? S_DOWN : S_UP;
            end
            S_UP: begin
                if (w_delta == '0) begin
                    w_err  = 1'b1;
                    w_code = c_err_stall;
                end else if (w_dn_step) begin
                    w_err  = 1'b1;
                    w_code = c_err_dir;
                end else if (!w_up_step || (in_count > c_top)) begin
                    w_err  = 1'b1;
                    w_code = c_err_mag;
                end else if (w_at_top) begin
                    w_peak = 1'b1;
                    w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                if (w_delta == '0) begin
                    w_err  = 1'b1;
                    w_code = c_err_stall;
                end else if (w_up_step) begin
                    w_err  = 1'b1;
                    w_code = c_err_dir;
                end else if (!w_dn_step || (in_count < c_bottom)) begin
                    w_err  = 1'b1;
                    w_code = c_err_mag;
                end else if (w_at_bottom) begin
                    w_valley = 1'b1;
                    w_next   = S_UP;
                end
            end
            default: begin
                w_next = S_INIT;
            end
        endcase

        // After a bad step, a sample sitting on a turnaround value tells us
        // unambiguously which phase the upstream counter is in.
        if (w_err) begin
            if (w_at_top) begin
                w_next = S_DOWN;
            end else if (w_at_bottom) begin
                w_next = S_UP;
            end
        end
    end

`ifdef STEP_MON_ERRCNT_EN
    logic [7:0] r_err_count;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_dir        <= 1'b0;
            r_peak       <= 1'b0;
            r_valley     <= 1'b0;
            r_step_err   <= 1'b0;
            r_err_code   <= 2'b00;
            r_err_sticky <= 1'b0;
            r_lap_count  <= '0;
            r_prev_count <= '0;
`ifdef STEP_MON_ERRCNT_EN
            r_err_count  <= 8'd0;
`endif
        end else begin
            r_peak     <= 1'b0;
            r_valley   <= 1'b0;
            r_step_err <= 1'b0;

            // clr is applied first so that a same-cycle error below can
            // still leave err_sticky set.
            if (clr) begin
                r_err_sticky <= 1'b0;
                r_lap_count  <= '0;
`ifdef STEP_MON_ERRCNT_EN
                r_err_count  <= 8'd0;
`endif
            end

            if (in_valid) begin
                r_state      <= w_next;
                r_dir        <= (w_next == S_DOWN);
                r_prev_count <= in_count;
                r_peak       <= w_peak;
                r_valley     <= w_valley;
                r_step_err   <= w_err;

                if (w_err) begin
                    r_err_code   <= w_code;
                    r_err_sticky <= 1'b1;
`ifdef STEP_MON_ERRCNT_EN
                    if (clr) begin
                        r_err_count <= 8'd1;
                    end else if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
`endif
                end

                // A same-cycle clr wins over the lap increment.
                if (w_valley && !clr && (r_lap_count != {LAP_W{1'b1}})) begin
                    r_lap_count <= r_lap_count + 1'b1;
                end
            end
        end
    end

    assign dir        = r_dir;
    assign peak       = r_peak;
    assign valley     = r_valley;
    assign step_err   = r_step_err;
    assign err_code   = r_err_code;
    assign err_sticky = r_err_sticky;
    assign lap_count  = r_lap_count;
    assign prev_count = r_prev_count;
`ifdef STEP_MON_ERRCNT_EN
    assign err_count  = r_err_count;
`endif

endmodule
`default_nettype wire
